// File: rtl/mni_pkt_sequencer.sv
// Sequences parser packets into myNodeInfo. It drops filtered types, pulses en_MNI, holds off the parser while myNodeInfo settles,
// and runs the member-node TX slot countdown.
module mni_pkt_sequencer #(
  parameter int WORD_WIDTH = 16,
  parameter int SETTLE_CYC = 2,
  parameter int DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [2:0]            rx_pktType,
  input  logic [WORD_WIDTH-1:0] rx_destID,
  input  logic [WORD_WIDTH-1:0] rx_hops,
  input  logic [WORD_WIDTH-1:0] rx_timeslot,
  input  logic [WORD_WIDTH-1:0] rx_energy,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  role,
  input  logic                  slot_tick,
  output logic                  en_MNI,
  output logic [2:0]            fPktType,
  output logic [WORD_WIDTH-1:0] destinationID,
  output logic [WORD_WIDTH-1:0] hops,
  output logic [WORD_WIDTH-1:0] timeslot,
  output logic [WORD_WIDTH-1:0] energy,
  output logic                  tx_slot_go,
  output logic                  slot_armed,
  output logic                  busy,
  output logic [DROP_W-1:0]     drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [3:0]            settle_cnt, settle_cnt_nx;
  logic [WORD_WIDTH-1:0] slot_cnt;
  logic                  xfer;
  logic                  fwd;

  // CHTimeslot is forwarded only when it targets this node and the node is a member.
  always_comb begin
    fwd = 1'b0;
    unique case (rx_pktType)
      3'b000, 3'b001, 3'b101: fwd = 1'b1;
      3'b100:                 fwd = (rx_destID == myNodeID) && !role;
      default:                fwd = 1'b0;
    endcase
  end

  assign xfer = rx_valid && rx_ready;

  always_comb begin
    state_nx      = state;
    settle_cnt_nx = settle_cnt;
    rx_ready      = (state == IDLE);
    en_MNI        = (state == ISSUE);
    busy          = (state != IDLE);
    unique case (state)
      IDLE:   if (xfer && fwd) state_nx = ISSUE;
      ISSUE: begin
        state_nx      = SETTLE;
        settle_cnt_nx = 4'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (settle_cnt == '0) state_nx = IDLE;
        else                  settle_cnt_nx = settle_cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      fPktType      <= '0;
      destinationID <= '0;
      hops          <= '0;
      timeslot      <= '0;
      energy        <= '0;
    end else if (xfer && fwd) begin
      fPktType      <= rx_pktType;
      destinationID <= rx_destID;
      hops          <= rx_hops;
      timeslot      <= rx_timeslot;
      energy        <= rx_energy;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      drop_cnt <= '0;
    end else if (xfer && !fwd && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Arm/disarm in ISSUE takes priority over a coincident slot_tick.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      slot_cnt   <= '0;
      slot_armed <= 1'b0;
      tx_slot_go <= 1'b0;
    end else begin
      tx_slot_go <= 1'b0;
      if (state == ISSUE && fPktType == 3'b100) begin
        slot_cnt   <= timeslot;
        slot_armed <= 1'b1;
      end else if (state == ISSUE && fPktType == 3'b000) begin
        slot_armed <= 1'b0;
      end else if (slot_tick && slot_armed) begin
        if (slot_cnt == '0) begin
          tx_slot_go <= 1'b1;
          slot_armed <= 1'b0;
        end else begin
          slot_cnt <= slot_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mni_pkt_sequencer.md
Name: mni_pkt_sequencer

Overview:
- Sits between the radio RX packet parser and myNodeInfo.
- Accepts one decoded packet at a time over a valid/ready handshake and filters packet types that myNodeInfo must never see.
- Presents stable fields to myNodeInfo, issues a single-cycle en_MNI pulse, then holds off the parser while myNodeInfo settles.
- For member nodes, it also arms a slot countdown from an accepted CHTimeslot packet and flags the node's TX slot.

Parameters:
WORD_WIDTH, 16, width of energy/destID/hops/timeslot fields
SETTLE_CYC, 2, cycles after en_MNI during which fields stay frozen and rx_ready stays low (1..15)
DROP_W, 8, width of saturating drop counter

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  reset, asynchronous, active-high (1 = reset)
rx_valid  in  1  parser has a packet
rx_ready  out  1  sequencer can accept
rx_pktType  in  3  packet type
rx_destID  in  WORD_WIDTH  destination ID
rx_hops  in  WORD_WIDTH  hop count
rx_timeslot  in  WORD_WIDTH  assigned slot
rx_energy  in  WORD_WIDTH  energy, 14.2 fixed point
myNodeID  in  WORD_WIDTH  from myNodeInfo
role  in  1  from myNodeInfo, 1 = cluster head
slot_tick  in  1  one-cycle pulse at each TDMA slot boundary
en_MNI  out  1  enable pulse to myNodeInfo
fPktType  out  3  registered type to myNodeInfo
destinationID, hops, timeslot, energy  out  WORD_WIDTH each  registered fields to myNodeInfo
tx_slot_go  out  1  one-cycle pulse: own TX slot reached
slot_armed  out  1  countdown active
busy  out  1  FSM not in IDLE
drop_cnt  out  DROP_W  packets dropped, saturating

Behaviour:
- Reset (async, immediate):
  - All outputs 0, except rx_ready = 1.
  - Field registers = 0; FSM = IDLE; slot counter = 0, disarmed.
  - Reset asserted mid-sequence aborts without completing; en_MNI drops immediately.
- Types:
  - 000 HB, 001 CHE, 100 CHTimeslot, 101 DATA: forwardable.
  - 010 INV, 011, 110, 111: always dropped.
  - 100 with rx_destID != myNodeID: dropped.
  - 100 while role = 1: dropped.
- Handshake: transfer occurs on rx_valid & rx_ready at a rising edge. rx_ready = 1 only in IDLE.
- FSM states:
  - IDLE → ISSUE: on transfer of a forwardable packet. All fields are latched into the output registers.
  - IDLE → IDLE: on transfer of a dropped packet. drop_cnt increments (saturates at 2^DROP_W−1); output field registers and en_MNI are untouched.
  - ISSUE: lasts exactly 1 cycle with en_MNI = 1. Next state is SETTLE, loading settle counter = SETTLE_CYC−1.
  - SETTLE: en_MNI = 0, fields held. Counter decrements each cycle; at 0, go to IDLE.
- Timing: with transfer at edge T, en_MNI is high in cycle T+1 and rx_ready is low for SETTLE_CYC+1 cycles. With SETTLE_CYC = 2, back-to-back throughput is 1 packet per 4 cycles.
- busy = (state != IDLE).
- Slot countdown:
  - Arm: in ISSUE with fPktType = 100, load slot counter = timeslot and set slot_armed = 1.
  - Disarm: in ISSUE with fPktType = 000 (new round), clear slot_armed and do not pulse tx_slot_go.
  - On slot_tick with slot_armed: if counter = 0, pulse tx_slot_go for 1 cycle and clear slot_armed; else decrement.
  - Arm/disarm and slot_tick in the same cycle: the load/clear wins and the tick is ignored.
  - timeslot = 0 fires on the first tick after arming.
  - Re-arm while armed reloads the counter with the new value.
  - slot_tick while disarmed: no effect.
- role is sampled combinationally only at IDLE transfer time. Later role changes do not affect an armed countdown.
- rx_valid held high while rx_ready = 0: no transfer, fields are not sampled, and the parser must hold data.

Test Plan:
- Reset: nrst = 1 for 5 cycles, then 0 → rx_ready = 1, en_MNI = 0, drop_cnt = 0, slot_armed = 0, all fields 0.
- HB then back-to-back CHE: HB (hops = 1, energy = 16'h8000) with rx_valid held, then CHE (destID = 16'h000C) → en_MNI pulses at T+1 and T+5, rx_ready low 3 cycles each time, fields change only at transfer edges.
- Drops: INV, type 011, CHTimeslot with destID = 21 (myNodeID = 12) → 3 single-cycle accepts, en_MNI never asserts, drop_cnt = 3.
- Slot countdown: role = 0, CHTimeslot with destID = 12, timeslot = 4, then slot_tick every 10 cycles → tx_slot_go pulses exactly on the 5th tick, then slot_armed = 0.
- Corner cases:
  - Arm in the same cycle as slot_tick: the tick is ignored, and with timeslot = 0 the go pulse fires on the next tick.
  - HB forwarded while armed: disarms, no go pulse.
  - role = 1 with a matching CHTimeslot: dropped, not armed.
- Mid-op reset and saturation:
  - nrst asserted during SETTLE → outputs clear asynchronously, FSM returns to IDLE.
  - 300 dropped packets → drop_cnt = 255.
